// File: rtl/ps2_keyboard_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | ps2_keyboard_pkg                                                |
// | Shared constants for the PS/2 keyboard receiver: segment        |
// | patterns, scan-code prefixes and the receiver state encoding.   |
// | Revision: 1.0                                                   |
// +-----------------------------------------------------------------+
package ps2_keyboard_pkg;

  // Active-high {g,f,e,d,c,b,a} patterns for 0..F; index 15 is leftmost
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  localparam logic [7:0] PREFIX_EXT   = 8'hE0;
  localparam logic [7:0] PREFIX_BREAK = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/ps2_keyboard_hex_to_7seg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | hex_to_7seg                                                     |
// | One hex nibble to an active-low seven-segment pattern.          |
// | Revision: 1.0                                                   |
// +-----------------------------------------------------------------+
module hex_to_7seg
  import ps2_keyboard_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Segments light when driven low, so invert the table entry
  assign seg = ~SEG_TABLE[hex];

endmodule
`default_nettype wire

// File: rtl/ps2_keyboard.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | ps2_keyboard                                                    |
// | PS/2 device-to-host receiver with make/break/extended prefix    |
// | tracking and a four-digit hex seven-segment readout.            |
// | Revision: 1.0                                                   |
// +-----------------------------------------------------------------+
module ps2_keyboard
  import ps2_keyboard_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int IDLE_TIMEOUT    = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [6:0] byte_h_digit_h,
  output logic [6:0] byte_h_digit_l,
  output logic [6:0] byte_l_digit_h,
  output logic [6:0] byte_l_digit_l
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TO_W = $clog2(IDLE_TIMEOUT + 1);

  logic            clk_s1, clk_s2, data_s1, data_s2;
  logic            clk_db;
  logic [DB_W-1:0] db_cnt;
  logic            strobe;
  rx_state_t       state;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;
  logic            parity;
  logic [TO_W-1:0] to_cnt;
  logic [7:0]      pending;
  logic [15:0]     display;
  logic            byte_valid;

  // Two-flop synchronisers for both PS/2 lines; lines idle high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= ps2_clk;
      clk_s2  <= clk_s1;
      data_s1 <= ps2_data;
      data_s2 <= data_s1;
    end
  end

  // Debounce: accept a new clock level after enough identical samples;
  // the strobe marks the accepted high-to-low transition
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_db <= 1'b1;
      db_cnt <= '0;
      strobe <= 1'b0;
    end else begin
      strobe <= 1'b0;
      if (clk_s2 == clk_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        db_cnt <= '0;
        clk_db <= clk_s2;
        strobe <= clk_db & ~clk_s2;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // A byte is good when the stop bit is high and data plus parity has odd weight
  assign byte_valid = strobe && (state == ST_STOP) && data_s2 && (^{shift, parity});

  // Frame receiver with an idle watchdog that discards partial frames
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shift   <= '0;
      parity  <= 1'b0;
      to_cnt  <= '0;
    end else begin
      if (strobe || state == ST_IDLE || !clk_db) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end

      if (strobe) begin
        case (state)
          ST_IDLE: begin
            if (!data_s2) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end
          end
          ST_DATA: begin
            shift   <= {data_s2, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= ST_PARITY;
          end
          ST_PARITY: begin
            parity <= data_s2;
            state  <= ST_STOP;
          end
          default: state <= ST_IDLE;
        endcase
      end else if (state != ST_IDLE && clk_db && to_cnt == TO_W'(IDLE_TIMEOUT - 1)) begin
        state   <= ST_IDLE;
        bit_cnt <= '0;
      end
    end
  end

  // Code tracker: prefixes are held until the following code byte arrives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 8'h00;
      display <= 16'h0000;
    end else if (byte_valid) begin
      if (shift == PREFIX_EXT || shift == PREFIX_BREAK) begin
        pending <= shift;
      end else begin
        display <= {pending, shift};
        pending <= 8'h00;
      end
    end
  end

  hex_to_7seg u_hh (.hex(display[15:12]), .seg(byte_h_digit_h));
  hex_to_7seg u_hl (.hex(display[11:8]),  .seg(byte_h_digit_l));
  hex_to_7seg u_lh (.hex(display[7:4]),   .seg(byte_l_digit_h));
  hex_to_7seg u_ll (.hex(display[3:0]),   .seg(byte_l_digit_l));

endmodule
`default_nettype wire

// File: tb/tb_ps2_keyboard.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_ps2_keyboard                                                 |
// | Directed bench: drives PS/2 frames and checks the readout.      |
// | Revision: 1.0                                                   |
// +-----------------------------------------------------------------+
module tb_ps2_keyboard;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [6:0] byte_h_digit_h, byte_h_digit_l, byte_l_digit_h, byte_l_digit_l;

  int tests_run = 0;
  int fails = 0;

  ps2_keyboard #(.DEBOUNCE_CYCLES(8), .IDLE_TIMEOUT(4096)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ps2_clk        (ps2_clk),
    .ps2_data       (ps2_data),
    .byte_h_digit_h (byte_h_digit_h),
    .byte_h_digit_l (byte_h_digit_l),
    .byte_l_digit_h (byte_l_digit_h),
    .byte_l_digit_l (byte_l_digit_l)
  );

  always #5 clk = ~clk;

  // Active-low segment pattern for one nibble
  function automatic logic [6:0] seg_of(input logic [3:0] n);
    logic [6:0] p;
    case (n)
      4'h0: p = 7'h3F; 4'h1: p = 7'h06; 4'h2: p = 7'h5B; 4'h3: p = 7'h4F;
      4'h4: p = 7'h66; 4'h5: p = 7'h6D; 4'h6: p = 7'h7D; 4'h7: p = 7'h07;
      4'h8: p = 7'h7F; 4'h9: p = 7'h6F; 4'hA: p = 7'h77; 4'hB: p = 7'h7C;
      4'hC: p = 7'h39; 4'hD: p = 7'h5E; 4'hE: p = 7'h79; default: p = 7'h71;
    endcase
    return ~p;
  endfunction

  function automatic logic [27:0] segs_of(input logic [15:0] v);
    return {seg_of(v[15:12]), seg_of(v[11:8]), seg_of(v[7:4]), seg_of(v[3:0])};
  endfunction

  function automatic logic [27:0] observed();
    return {byte_h_digit_h, byte_h_digit_l, byte_l_digit_h, byte_l_digit_l};
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    wait_clk(20);
    ps2_clk = 1'b0;
    wait_clk(40);
    ps2_clk = 1'b1;
    wait_clk(20);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_parity);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(bad_parity ? (^b) : ~(^b));
    send_bit(1'b1);
    ps2_data = 1'b1;
    wait_clk(20);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wait_clk(4);
    tests_run++;
    if (observed() !== {4{7'h40}}) begin
      fails++;
      $display("FAIL reset_outputs: got %h want %h", observed(), {4{7'h40}});
    end
    rst_n = 1'b1;
    wait_clk(200);
    tests_run++;
    if (observed() !== segs_of(16'h0000)) begin
      fails++;
      $display("FAIL idle_after_reset: got %h want %h", observed(), segs_of(16'h0000));
    end
  endtask

  task automatic test_sequence(input string name, input logic [7:0] bytes [],
                               input logic [15:0] expv []);
    for (int i = 0; i < bytes.size(); i++) begin
      send_frame(bytes[i], 1'b0);
      tests_run++;
      if (observed() !== segs_of(expv[i])) begin
        fails++;
        $display("FAIL %s[%0d] byte %h: got %h want %h (display %h)",
                 name, i, bytes[i], observed(), segs_of(expv[i]), expv[i]);
      end
    end
  endtask

  task automatic test_make();
    test_sequence("make", '{8'h1C, 8'h1C}, '{16'h001C, 16'h001C});
  endtask

  task automatic test_break();
    test_sequence("break", '{8'hF0, 8'h1C}, '{16'h001C, 16'hF01C});
  endtask

  task automatic test_extended();
    test_sequence("extended",
                  '{8'hE0, 8'h14, 8'hE0, 8'h14, 8'hE0, 8'hF0, 8'h14},
                  '{16'hF01C, 16'hE014, 16'hE014, 16'hE014, 16'hE014, 16'hE014, 16'hF014});
  endtask

  task automatic test_error_frame();
    send_frame(8'h1C, 1'b1);
    tests_run++;
    if (observed() !== segs_of(16'hF014)) begin
      fails++;
      $display("FAIL bad_parity: got %h want %h", observed(), segs_of(16'hF014));
    end
    send_frame(8'h2A, 1'b0);
    tests_run++;
    if (observed() !== segs_of(16'h002A)) begin
      fails++;
      $display("FAIL after_bad_parity: got %h want %h", observed(), segs_of(16'h002A));
    end
  endtask

  task automatic test_glitch();
    // Data low during the glitch: an accepted edge would look like a start bit
    ps2_data = 1'b0;
    wait_clk(10);
    ps2_clk = 1'b0;
    wait_clk(3);
    ps2_clk = 1'b1;
    wait_clk(10);
    ps2_data = 1'b1;
    wait_clk(100);
    send_frame(8'h15, 1'b0);
    tests_run++;
    if (observed() !== segs_of(16'h0015)) begin
      fails++;
      $display("FAIL glitch: got %h want %h", observed(), segs_of(16'h0015));
    end
  endtask

  task automatic test_timeout();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    ps2_data = 1'b1;
    wait_clk(4300);
    send_frame(8'h1C, 1'b0);
    tests_run++;
    if (observed() !== segs_of(16'h001C)) begin
      fails++;
      $display("FAIL timeout_recover: got %h want %h", observed(), segs_of(16'h001C));
    end
  endtask

  task automatic test_reset_mid_frame();
    send_frame(8'hE0, 1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    rst_n = 1'b0;
    wait_clk(3);
    tests_run++;
    if (observed() !== segs_of(16'h0000)) begin
      fails++;
      $display("FAIL reset_mid_frame: got %h want %h", observed(), segs_of(16'h0000));
    end
    rst_n = 1'b1;
    ps2_data = 1'b1;
    wait_clk(50);
    send_frame(8'h29, 1'b0);
    tests_run++;
    if (observed() !== segs_of(16'h0029)) begin
      fails++;
      $display("FAIL after_mid_reset: got %h want %h", observed(), segs_of(16'h0029));
    end
  endtask

  initial begin
    test_reset();
    test_make();
    test_break();
    test_extended();
    test_error_frame();
    test_glitch();
    test_timeout();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
`default_nettype wire
